// File: rtl/mpc_pkg.sv
// mpc_pkg: shared types and constants for the pad-mux configuration controller
package mpc_pkg;
    localparam int CFG_W      = 4;
    localparam int NUM_MACROS = 4;
    localparam int TMR_W      = 8;
    typedef enum logic [1:0] {IDLE, DRAIN, SWITCH, SETTLE} state_e;
    function automatic logic cfg_legal(input logic [15:0] mask, input logic [CFG_W-1:0] c);
        return mask[c];
    endfunction
endpackage

// File: rtl/mpc_guard_timer.sv
// mpc_guard_timer: loadable down-counter that saturates at zero and flags it
module mpc_guard_timer
    import mpc_pkg::*;
#(
    parameter logic [TMR_W-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [TMR_W-1:0] val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [TMR_W-1:0] cnt_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= RST_VAL;
        else if (load_i) cnt_q <= val_i;
        else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/mpc_cfg_ctrl.sv
// mpc_cfg_ctrl: sequences pad-mux configuration changes with output drain,
// switch and macro-reset settle phases
module mpc_cfg_ctrl
    import mpc_pkg::*;
#(
    parameter int                GUARD_CYCLES  = 8,
    parameter int                SETTLE_CYCLES = 4,
    parameter logic [15:0]       VALID_MASK    = 16'hFFFF,
    parameter logic [CFG_W-1:0]  RESET_CFG     = 4'd0
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  cfg_req_valid,
    input  logic [CFG_W-1:0]      cfg_req_cfg,
    output logic                  cfg_req_ready,
    output logic [CFG_W-1:0]      configuration,
    output logic                  pad_oe_en,
    output logic [NUM_MACROS-1:0] macro_rst,
    output logic                  busy,
    output logic                  cfg_done,
    output logic                  cfg_err
);
    localparam logic [TMR_W-1:0] G_LD = TMR_W'(GUARD_CYCLES - 1);
    localparam logic [TMR_W-1:0] S_LD = TMR_W'(SETTLE_CYCLES - 1);
    state_e                state_q;
    logic [CFG_W-1:0]      cfg_q, pend_q;
    logic                  pad_q, done_q, err_q, req_q;
    logic [NUM_MACROS-1:0] mrst_q;
    logic                  hs, legal, chg, tmr_zero;
    assign hs    = cfg_req_valid && state_q == IDLE;
    assign legal = cfg_legal(VALID_MASK, cfg_req_cfg);
    assign chg   = hs && legal && cfg_req_cfg != cfg_q;
    // Reset preloads the settle count so the post-reset settle needs no extra entry edge
    mpc_guard_timer #(.RST_VAL(S_LD)) u_timer (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .load_i (chg || state_q == SWITCH),
        .val_i  (chg ? G_LD : S_LD),
        .dec_i  (state_q == DRAIN || state_q == SETTLE),
        .zero_o (tmr_zero)
    );
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= SETTLE;
            cfg_q   <= RESET_CFG;
            pend_q  <= RESET_CFG;
            pad_q   <= 1'b0;
            mrst_q  <= '1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: if (hs) begin
                    if (!legal) err_q <= 1'b1;
                    else if (!chg) done_q <= 1'b1;
                    else begin
                        pend_q  <= cfg_req_cfg;
                        pad_q   <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: if (tmr_zero) state_q <= SWITCH;
                SWITCH: begin
                    cfg_q   <= pend_q;
                    mrst_q  <= '1;
                    state_q <= SETTLE;
                end
                SETTLE: if (tmr_zero) begin
                    // Only a requested change reports completion; the post-reset settle does not
                    done_q  <= req_q;
                    req_q   <= 1'b0;
                    pad_q   <= 1'b1;
                    mrst_q  <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign cfg_req_ready = state_q == IDLE;
    assign busy          = state_q != IDLE;
    assign configuration = cfg_q;
    assign pad_oe_en     = pad_q;
    assign macro_rst     = mrst_q;
    assign cfg_done      = done_q;
    assign cfg_err       = err_q;
endmodule

// File: tb/tb_mpc_cfg_ctrl.sv
// tb_mpc_cfg_ctrl: directed checks of reset, change, no-op, reject, hold-off and mid-sequence reset
module tb_mpc_cfg_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [3:0] req_cfg = 4'd0;
    logic       ready, oe, bsy, done, err;
    logic [3:0] cfg, mrst;
    int checks = 0;
    int errors = 0;

    mpc_cfg_ctrl #(.GUARD_CYCLES(8), .SETTLE_CYCLES(4), .VALID_MASK(16'h000F), .RESET_CFG(4'd0)) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .cfg_req_valid (valid),
        .cfg_req_cfg   (req_cfg),
        .cfg_req_ready (ready),
        .configuration (cfg),
        .pad_oe_en     (oe),
        .macro_rst     (mrst),
        .busy          (bsy),
        .cfg_done      (done),
        .cfg_err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (3) tick();
        check("rst_cfg", 16'(cfg), 16'h0);
        check("rst_oe", 16'(oe), 16'h0);
        check("rst_mrst", 16'(mrst), 16'hF);
        check("rst_ready", 16'(ready), 16'h0);
        check("rst_busy", 16'(bsy), 16'h1);
        check("rst_done", 16'(done), 16'h0);
        check("rst_err", 16'(err), 16'h0);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("rel_oe", 16'(oe), 16'(k == 4));
            check("rel_done", 16'(done), 16'h0);
        end
        check("rel_ready", 16'(ready), 16'h1);
        check("rel_mrst", 16'(mrst), 16'h0);
        // change 0 -> 2
        valid = 1'b1;
        req_cfg = 4'd2;
        tick();
        valid = 1'b0;
        check("chg_busy", 16'(bsy), 16'h1);
        check("chg_ready", 16'(ready), 16'h0);
        for (int k = 1; k <= 14; k++) begin
            check("chg_oe", 16'(oe), 16'(k == 14));
            check("chg_cfg", 16'(cfg), (k >= 10) ? 16'h2 : 16'h0);
            check("chg_done", 16'(done), 16'(k == 14));
            check("chg_mrst", 16'(mrst), (k >= 10 && k <= 13) ? 16'hF : 16'h0);
            if (k < 14) tick();
        end
        // no-op request for the current configuration
        valid = 1'b1;
        req_cfg = 4'd2;
        tick();
        valid = 1'b0;
        check("nop_done", 16'(done), 16'h1);
        check("nop_oe", 16'(oe), 16'h1);
        check("nop_busy", 16'(bsy), 16'h0);
        tick();
        check("nop_done2", 16'(done), 16'h0);
        check("nop_oe2", 16'(oe), 16'h1);
        // illegal value under mask 000F
        valid = 1'b1;
        req_cfg = 4'd9;
        tick();
        valid = 1'b0;
        check("err_pulse", 16'(err), 16'h1);
        check("err_done", 16'(done), 16'h0);
        check("err_cfg", 16'(cfg), 16'h2);
        check("err_oe", 16'(oe), 16'h1);
        check("err_mrst", 16'(mrst), 16'h0);
        check("err_ready", 16'(ready), 16'h1);
        tick();
        check("err_clear", 16'(err), 16'h0);
        // change to 1, then hold a second request for 3 throughout
        valid = 1'b1;
        req_cfg = 4'd1;
        tick();
        req_cfg = 4'd3;
        for (int k = 1; k <= 14; k++) begin
            check("hold_ready", 16'(ready), 16'(k == 14));
            check("hold_cfg", 16'(cfg), (k >= 10) ? 16'h1 : 16'h2);
            check("hold_done", 16'(done), 16'(k == 14));
            if (k < 14) tick();
        end
        tick();
        valid = 1'b0;
        check("hold_acc_busy", 16'(bsy), 16'h1);
        check("hold_acc_oe", 16'(oe), 16'h0);
        check("hold_acc_cfg", 16'(cfg), 16'h1);
        // reset during DRAIN discards the pending 3
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("mid_cfg", 16'(cfg), 16'h0);
        check("mid_mrst", 16'(mrst), 16'hF);
        check("mid_oe", 16'(oe), 16'h0);
        check("mid_busy", 16'(bsy), 16'h1);
        check("mid_done", 16'(done), 16'h0);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("mid_rel_done", 16'(done), 16'h0);
        end
        check("mid_rel_oe", 16'(oe), 16'h1);
        check("mid_rel_cfg", 16'(cfg), 16'h0);
        check("mid_rel_ready", 16'(ready), 16'h1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mpc_cfg_ctrl.md
MPC_CFG_CTRL -- requirements
Module: mpc_cfg_ctrl

Interface
REQ-001 SHALL have parameter GUARD_CYCLES, default 8, pad-output drain time in cycles before a configuration change (legal range 1..255).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, cycles after a change before pads re-enable (legal range 1..255).
REQ-003 SHALL have parameter VALID_MASK, default 16'hFFFF, where bit n set means configuration value n is legal.
REQ-004 SHALL have parameter RESET_CFG, default 4'd0, the configuration applied out of reset.
REQ-005 SHALL have one clock and a synchronous, active-high reset, named as the codebase does:
- wb_clk_i  in  1  sole clock; all state updates on its rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
REQ-006 SHALL have these further ports:
- cfg_req_valid  in  1  a configuration request is present.
- cfg_req_cfg  in  4  requested configuration value.
- cfg_req_ready  out  1  controller accepts the request this cycle.
- configuration  out  4  registered select driving the pad multiplexer's configuration input.
- pad_oe_en  out  1  gate ANDed externally into all IO_*_oe buses; 0 forces pads to input.
- macro_rst  out  4  per-macro reset, bit n for macro n.
- busy  out  1  high in any state other than IDLE.
- cfg_done  out  1  one-cycle pulse on completion.
- cfg_err  out  1  one-cycle pulse on rejection.

Function
REQ-007 SHALL implement the states IDLE, DRAIN, SWITCH and SETTLE.
REQ-008 SHALL drive cfg_req_ready high only in IDLE; a handshake occurs when cfg_req_valid and cfg_req_ready are both high.
REQ-009 On a handshake with VALID_MASK[cfg_req_cfg]==0, SHALL pulse cfg_err in the next cycle, stay in IDLE, and leave configuration, pad_oe_en and macro_rst unchanged.
REQ-010 On a legal request equal to the current configuration, SHALL pulse cfg_done in the next cycle with no gating (no-op).
REQ-011 On a legal request that differs from the current configuration, SHALL:
- capture cfg_req_cfg into a pending register;
- enter DRAIN with pad_oe_en=0 for exactly GUARD_CYCLES cycles.
REQ-012 SHALL spend exactly one cycle in SWITCH, at the end of which configuration loads the pending value.
REQ-013 SHALL spend exactly SETTLE_CYCLES cycles in SETTLE, with macro_rst=4'hF and pad_oe_en=0.
REQ-014 SHALL return from SETTLE to IDLE, and in that first IDLE cycle set pad_oe_en=1, macro_rst=0 and pulse cfg_done.
REQ-015 Timing, for a handshake at cycle T with G=GUARD_CYCLES and S=SETTLE_CYCLES:
- pad_oe_en=0 over cycles T+1..T+G+S+1;
- new configuration visible at T+G+2;
- cfg_done=1 at T+G+S+2.
REQ-016 SHALL ignore cfg_req_valid while busy; the request is neither captured nor queued, and the requester must hold it.
REQ-017 SHALL load a down-counter with the parameter value minus 1 on entry to DRAIN or SETTLE and leave the state when the count reaches 0; the counter SHALL NOT wrap.
REQ-018 SHALL keep configuration stable in every cycle except the single SWITCH-to-SETTLE edge.
REQ-019 SHALL never assert cfg_done and cfg_err in the same cycle.

Reset
REQ-020 While wb_rst_i=1, SHALL set:
- configuration=RESET_CFG, pad_oe_en=0, macro_rst=4'hF;
- cfg_req_ready=0, busy=1, cfg_done=0, cfg_err=0;
- pending register=RESET_CFG.
REQ-021 On the first cycle after reset deasserts, SHALL enter SETTLE with the counter loaded, so pads enable SETTLE_CYCLES cycles later with no cfg_done pulse.
REQ-022 Reset asserted mid-sequence SHALL abandon the pending request and restore the REQ-020 values on the next edge.

Structure
REQ-023 Package mpc_pkg SHALL hold:
- the state encoding typedef;
- CFG_W=4, NUM_MACROS=4;
- the timer width constant (8).
REQ-024 Sub-module mpc_guard_timer SHALL be the load/decrement/zero-flag counter; the FSM and the output registers stay in mpc_cfg_ctrl.

Verification
REQ-025 Defaults (G=8, S=4): reset release -> pad_oe_en rises after 4 cycles, cfg_done stays 0, cfg_req_ready=1.
REQ-026 Request 4'd2 from cfg 0, handshake at T -> pad_oe_en=0 at T+1..T+13; configuration=2 at T+10; cfg_done at T+14.
REQ-027 VALID_MASK=16'h000F, request 4'd9 -> cfg_err pulse at T+1; configuration, pad_oe_en and macro_rst unchanged.
REQ-028 Request equal to current cfg -> cfg_done at T+1; pad_oe_en never drops.
REQ-029 A second request held valid during a sequence -> not accepted until IDLE; accepted on the cycle cfg_done pulses.
REQ-030 wb_rst_i pulsed during DRAIN -> configuration=RESET_CFG, macro_rst=4'hF on the next edge; pending value discarded.
